// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first, optional
// odd/even parity, one or two stop bits, with a valid/ready handshake on the input word.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        parity_mode,
  input  logic              stop_bits,
  output logic              TX_out,
  output logic              busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud_cnt;
  logic [IDX_W-1:0]    r_bit_idx;
  logic                r_stop_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_two_stop;

  logic w_bit_end;
  logic w_last_stop;
  logic w_accept;
  logic w_par_en;
  logic w_par_bit;

  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  // Final cycle of the last stop bit: the only non-idle cycle that can take a new word.
  assign w_last_stop = (r_state == STOP) && w_bit_end && (r_stop_cnt == r_two_stop);
  assign tx_ready    = !reset && ((r_state == IDLE) || w_last_stop);
  assign w_accept    = tx_valid && tx_ready;

  // Parity is resolved at acceptance so later input changes cannot disturb the frame.
  assign w_par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign w_par_bit = (parity_mode == 2'b10) ? ^tx_data : ~^tx_data;

  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      TX_out     <= 1'b1;
      busy       <= 1'b0;
    end else if (w_accept) begin
      r_state    <= START;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= tx_data;
      r_par_en   <= w_par_en;
      r_par_bit  <= w_par_bit;
      r_two_stop <= stop_bits;
      TX_out     <= 1'b0;
      busy       <= 1'b1;
    end else begin
      if (r_state != IDLE) begin
        r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          TX_out <= 1'b1;
          busy   <= 1'b0;
        end
        START: begin
          if (w_bit_end) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            TX_out    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == IDX_LAST) begin
              r_stop_cnt <= 1'b0;
              if (r_par_en) begin
                r_state <= PARITY;
                TX_out  <= r_par_bit;
              end else begin
                r_state <= STOP;
                TX_out  <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              TX_out    <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state    <= STOP;
            r_stop_cnt <= 1'b0;
            TX_out     <= 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_state    <= IDLE;
              r_stop_cnt <= 1'b0;
              busy       <= 1'b0;
            end else begin
              r_stop_cnt <= 1'b1;
            end
            TX_out <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          TX_out  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the next generation of the team's fixed 8-bit serializer. It adds configurable data width, a built-in baud divider, selectable parity (none/odd/even), one or two stop bits, and a valid/ready handshake. Back-to-back frames are supported with no idle gap. It sits between a byte-stream producer (a FIFO or register interface) and the serial pin, and drives the line directly.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit (baud divisor); must be >= 1.
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  block accepts a word this cycle; transfer occurs when tx_valid && tx_ready at a rising edge.
- tx_data  in  DATA_W  word to send, transmitted LSB first.
- parity_mode  in  2  00 none, 01 odd, 10 even, 11 reserved (treated as none).
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- TX_out  out  1  serial line, registered; idles high.
- busy  out  1  a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - TX_out=1, busy=0, tx_ready=1.
  - On acceptance, latch tx_data, parity_mode and stop_bits into internal registers, then go to START.
- Configuration is sampled only at acceptance. Changes to the inputs mid-frame have no effect on the current frame.
- **START:** TX_out=0 for CLKS_PER_BIT cycles, then DATA.
- **DATA:**
  - TX_out = data[bit_idx], starting at bit_idx=0.
  - Each bit is held CLKS_PER_BIT cycles.
  - After bit DATA_W-1, go to PARITY if parity is enabled, else STOP.
- **PARITY:**
  - Even mode: TX_out = XOR of the data bits.
  - Odd mode: TX_out = XNOR of the data bits.
  - Held CLKS_PER_BIT cycles, then STOP.
- **STOP:**
  - TX_out=1 for CLKS_PER_BIT cycles if stop_bits=0, or 2*CLKS_PER_BIT cycles if stop_bits=1.
  - Then return to IDLE, or to START directly if a word is accepted in the final stop cycle.
- **Counters:**
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - Bit index runs 0..DATA_W-1 (width $clog2(DATA_W)).
  - A stop counter of 1 bit tracks the second stop bit.
- **tx_ready:**
  - High in IDLE.
  - Also high during the last clk cycle of the final stop bit, enabling back-to-back frames.
  - Low in all other cycles and while reset is high.
- busy is high in every non-IDLE state.

## Timing
- **Reset (synchronous):**
  - At the next rising edge: state=IDLE, TX_out=1, busy=0, all counters=0.
  - tx_ready=0 while reset is high and 1 in the first cycle after reset is released.
  - tx_valid is ignored while reset is high.
- **Reset mid-frame:** the frame is abandoned. TX_out=1 and busy=0 from the next edge, with no retransmission.
- **Latency:** acceptance at edge N → TX_out=0 and busy=1 from edge N+1.
- **Frame length** = (1 + DATA_W + P + S) * CLKS_PER_BIT cycles, where P = 1 if parity is enabled and S = 1 or 2.
- **Back-to-back frames:** a word accepted in the last stop cycle produces its start bit in the immediately following cycle. busy stays high with no idle cycle on TX_out.
- **CLKS_PER_BIT=1:** one bit per clk. All rules above still hold.
- The output is fully registered. No combinational path from tx_data or parity_mode to TX_out.

## Test plan
All scenarios use DATA_W=8, CLKS_PER_BIT=4.
1. **No parity:** send 0xA5, parity_mode=00, stop_bits=0.
   - TX_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
   - busy high exactly 40 cycles; tx_ready high again at cycle 40.
2. **Odd/even parity:** 0xA5 with parity_mode=01 → parity bit 1; with parity_mode=10 → parity bit 0. Frame length 44 cycles in both cases.
3. **Two stop bits:** 0x07, parity_mode=10, stop_bits=1 → parity bit 1, TX_out high for 8 stop cycles, frame length 48 cycles.
4. **Back-to-back:** hold tx_valid high with 0x55 then 0x0F.
   - The second start bit begins in the cycle after the first frame's final stop cycle.
   - busy is never low between the frames; tx_ready is a 1-cycle pulse.
5. **Reset mid-frame:** assert reset during DATA bit 3 of 0xFF.
   - Next cycle: TX_out=1, busy=0. tx_ready=1 after reset is released.
   - A following 0x3C frame is bit-exact.
6. **Config change mid-frame:** toggle parity_mode and stop_bits during the DATA state → the current frame uses the latched values; the next frame uses the new ones.
